// File: rtl/i2c_codec_target.sv
// I2C write-only target standing in for the audio codec control port.
// Accepts one 16-bit {reg_addr[6:0], reg_data[8:0]} word per transfer and commits it to a small register file.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR    = 7'b0011010,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] RST_REG     = 7'd15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE_H, ACK_H, BYTE_L, ACK_L, IGNORE
  } state_t;

  state_t                      state;
  logic [SYNC_STAGES-1:0]      scl_sync, sda_sync;
  logic                        scl_q, sda_q;
  logic                        sda_oe;
  logic [2:0]                  cnt;
  logic [7:0]                  shreg, hi_byte;
  logic [NUM_REGS-1:0][8:0]    regs;

  logic       scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0] nxt;
  logic [6:0] c_addr;
  logic [8:0] c_data;
  logic [AW-1:0] rd_idx, wr_idx;

  assign io_sda   = sda_oe ? 1'b0 : 1'bz;
  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  // SCL must be high on both samples so an SDA edge racing an SCL edge is not misread
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign nxt      = {shreg[6:0], sda_s};
  assign c_addr   = hi_byte[7:1];
  assign c_data   = {hi_byte[0], shreg};
  assign rd_idx   = AW'(i_rd_addr);
  assign wr_idx   = AW'(c_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // idle bus level, so leaving reset never fabricates a START/STOP
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      state      <= IDLE;
      sda_oe     <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      hi_byte    <= '0;
      regs       <= '0;
      o_rd_data  <= '0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], io_sda};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      o_wr_valid <= 1'b0;
      o_rd_data  <= (32'(i_rd_addr) < NUM_REGS) ? regs[rd_idx] : '0;

      if (start) begin
        state  <= ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= nxt;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (nxt == {DEV_ADDR, 1'b0}) begin
                state  <= ACK_A;
                o_busy <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          BYTE_H, BYTE_L: if (scl_rise) begin
            shreg <= nxt;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (state == BYTE_H) begin
                hi_byte <= nxt;
                state   <= ACK_H;
              end else begin
                state <= ACK_L;
              end
            end
          end
          // first SCL fall starts driving the ACK, the second ends it
          ACK_A, ACK_H, ACK_L: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
              if (state == ACK_L) begin
                o_wr_valid <= 1'b1;
                o_wr_addr  <= c_addr;
                o_wr_data  <= c_data;
                if (c_addr == RST_REG)
                  regs <= '0;
                else if (32'(c_addr) < NUM_REGS)
                  regs[wr_idx] <= c_data;
              end
            end else begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              case (state)
                ACK_A:   state <= BYTE_H;
                ACK_H:   state <= BYTE_L;
                default: state <= IGNORE;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
